// File: rtl/ras_stack_if.sv
// Purpose: F1 decoder / flush / checkpoint signal bundle between the fetch pipeline and the RAS.
// Latency: wires only; all timing is set by the attached modules.
// Backpressure: none; F1 advance is qualified by f1_vld_i, and the RAS never stalls.
interface ras_stack_if #(
  parameter int PTR_W = 4
);
  logic             f1_vld_i;
  logic             brdec_brext_f1_i;
  logic [1:0]       brdec_rasctl_f1_i;
  logic [63:0]      brdec_rasdat_f1_i;
  logic             flush_vld_i;
  logic [PTR_W-1:0] flush_tos_i;
  logic [PTR_W:0]   flush_cnt_i;
  logic [63:0]      ras_pcdata_f0_o;
  logic [PTR_W-1:0] ras_tos_o;
  logic [PTR_W:0]   ras_cnt_o;
  logic             ras_empty_o;
  logic             ras_full_o;

  // Fetch/backend side: drives decoder control and flush checkpoints, consumes the prediction.
  modport master (
    output f1_vld_i, brdec_brext_f1_i, brdec_rasctl_f1_i, brdec_rasdat_f1_i,
    output flush_vld_i, flush_tos_i, flush_cnt_i,
    input  ras_pcdata_f0_o, ras_tos_o, ras_cnt_o, ras_empty_o, ras_full_o
  );

  // Stack side.
  modport slave (
    input  f1_vld_i, brdec_brext_f1_i, brdec_rasctl_f1_i, brdec_rasdat_f1_i,
    input  flush_vld_i, flush_tos_i, flush_cnt_i,
    output ras_pcdata_f0_o, ras_tos_o, ras_cnt_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/ras_stack.sv
// Purpose: circular return-address stack with pointer-only checkpoint restore on flush.
// Latency: a push becomes visible on ras_pcdata_f0_o one cycle later (no same-cycle bypass).
// Backpressure: none; every qualified F1 operation is absorbed, and a full push overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ras_stack_if.slave  ras_if
);

  localparam logic [1:0] L_CTL_NONE = 2'b00;
  localparam logic [1:0] L_CTL_PUSH = 2'b01;
  localparam logic [1:0] L_CTL_POP  = 2'b10;
  localparam logic [1:0] L_CTL_POPPUSH = 2'b11;

  localparam logic [PTR_W:0] L_CNT_MAX = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] L_CNT_ONE = (PTR_W+1)'(1);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [PTR_W:0]   r_cnt;

  logic             w_upd;
  logic [63:0]      w_retaddr;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;
  logic [PTR_W-1:0] w_nxt_tos;
  logic [PTR_W:0]   w_nxt_cnt;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;

  // A flush kills any same-cycle F1 update; only advancing packets with a branch touch the stack.
  assign w_upd     = ras_if.f1_vld_i & ras_if.brdec_brext_f1_i & ~ras_if.flush_vld_i;
  assign w_retaddr = ras_if.brdec_rasdat_f1_i + 64'h4;
  assign w_tos_inc = r_tos + 1'b1;
  assign w_tos_dec = r_tos - 1'b1;

  // Next pointer/count and the single entry write: flush restores pointers only, entries are left alone.
  always_comb begin
    w_nxt_tos = r_tos;
    w_nxt_cnt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_tos;
    if (ras_if.flush_vld_i) begin
      w_nxt_tos = ras_if.flush_tos_i;
      w_nxt_cnt = (ras_if.flush_cnt_i > L_CNT_MAX) ? L_CNT_MAX : ras_if.flush_cnt_i;
    end else if (w_upd) begin
      case (ras_if.brdec_rasctl_f1_i)
        L_CTL_PUSH: begin
          w_wr_en   = 1'b1;
          w_wr_idx  = w_tos_inc;
          w_nxt_tos = w_tos_inc;
          w_nxt_cnt = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + L_CNT_ONE;
        end
        L_CTL_POP: begin
          // Underflow is silently ignored so the prediction keeps pointing at the same slot.
          if (r_cnt != '0) begin
            w_nxt_tos = w_tos_dec;
            w_nxt_cnt = r_cnt - L_CNT_ONE;
          end
        end
        L_CTL_POPPUSH: begin
          // Replace the top in place; from empty this creates a single live entry.
          w_wr_en  = 1'b1;
          w_wr_idx = r_tos;
          if (r_cnt == '0) begin
            w_nxt_cnt = L_CNT_ONE;
          end
        end
        L_CTL_NONE: begin
          w_nxt_tos = r_tos;
        end
        default: begin
          w_nxt_tos = r_tos;
        end
      endcase
    end
  end

  // Pointer state register; reset wins over flush and update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tos <= '0;
      r_cnt <= '0;
    end else begin
      r_tos <= w_nxt_tos;
      r_cnt <= w_nxt_cnt;
    end
  end

  // Entry array: cleared on reset, otherwise at most one entry written per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 64'h0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_retaddr;
    end
  end

  // Prediction is read from registered state and suppressed when the stack is empty.
  assign ras_if.ras_pcdata_f0_o = (r_cnt == '0) ? 64'h0 : r_mem[r_tos];
  assign ras_if.ras_tos_o       = r_tos;
  assign ras_if.ras_cnt_o       = r_cnt;
  assign ras_if.ras_empty_o     = (r_cnt == '0);
  assign ras_if.ras_full_o      = (r_cnt == L_CNT_MAX);

endmodule

// File: tb/tb_ras_stack.sv
// Purpose: directed, self-checking bench for the return-address stack.
// Latency: outputs sampled 1ns after each rising edge, inputs changed right after sampling.
// Backpressure: none to model; the DUT accepts every cycle.
module tb_ras_stack;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ras_stack_if #(.PTR_W(4)) rif ();

  ras_stack #(.DEPTH(16), .PTR_W(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ras_if (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic        brext;
    logic [1:0]  ctl;
    logic [63:0] dat;
    logic        fl;
    logic [3:0]  ftos;
    logic [4:0]  fcnt;
    logic [63:0] e_pc;
    logic [3:0]  e_tos;
    logic [4:0]  e_cnt;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string name, logic r, logic v, logic b, logic [1:0] c,
                              logic [63:0] d, logic f, logic [3:0] ft, logic [4:0] fc,
                              logic [63:0] pc, logic [3:0] tos, logic [4:0] cnt,
                              logic emp, logic full);
    vec_t x;
    x.name = name; x.rst = r; x.vld = v; x.brext = b; x.ctl = c; x.dat = d;
    x.fl = f; x.ftos = ft; x.fcnt = fc;
    x.e_pc = pc; x.e_tos = tos; x.e_cnt = cnt; x.e_empty = emp; x.e_full = full;
    return x;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(string tag, logic [63:0] pc, logic [3:0] tos, logic [4:0] cnt,
                             logic emp, logic full);
    check({tag, ".pc"},    rif.ras_pcdata_f0_o, pc);
    check({tag, ".tos"},   64'(rif.ras_tos_o), 64'(tos));
    check({tag, ".cnt"},   64'(rif.ras_cnt_o), 64'(cnt));
    check({tag, ".empty"}, 64'(rif.ras_empty_o), 64'(emp));
    check({tag, ".full"},  64'(rif.ras_full_o), 64'(full));
  endtask

  // Apply one cycle of stimulus, then return to idle inputs 1ns after the edge.
  task automatic cyc(logic r, logic v, logic b, logic [1:0] c, logic [63:0] d,
                     logic f, logic [3:0] ft, logic [4:0] fc);
    rst = r;
    rif.f1_vld_i = v;
    rif.brdec_brext_f1_i = b;
    rif.brdec_rasctl_f1_i = c;
    rif.brdec_rasdat_f1_i = d;
    rif.flush_vld_i = f;
    rif.flush_tos_i = ft;
    rif.flush_cnt_i = fc;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rif.f1_vld_i = 1'b0;
    rif.brdec_brext_f1_i = 1'b0;
    rif.brdec_rasctl_f1_i = 2'b00;
    rif.brdec_rasdat_f1_i = 64'h0;
    rif.flush_vld_i = 1'b0;
    rif.flush_tos_i = 4'h0;
    rif.flush_cnt_i = 5'h0;
  endtask

  task automatic push(logic [63:0] d);
    cyc(1'b0, 1'b1, 1'b1, 2'b01, d, 1'b0, 4'h0, 5'h0);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b1, 1'b1, 2'b10, 64'h0, 1'b0, 4'h0, 5'h0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 4'h0, 5'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    rif.f1_vld_i = 1'b0;
    rif.brdec_brext_f1_i = 1'b0;
    rif.brdec_rasctl_f1_i = 2'b00;
    rif.brdec_rasdat_f1_i = 64'h0;
    rif.flush_vld_i = 1'b0;
    rif.flush_tos_i = 4'h0;
    rif.flush_cnt_i = 5'h0;

    //               name        rst  vld  brx  ctl    dat                     fl   ftos  fcnt    pc        tos  cnt    emp  full
    vecs[0]  = mk("reset",       1,   0,   0,   2'b00, 64'h0,                  0,   4'd0, 5'd0,   64'h0,    4'd0, 5'd0,  1, 0);
    vecs[1]  = mk("push1000",    0,   1,   1,   2'b01, 64'h1000,               0,   4'd0, 5'd0,   64'h1004, 4'd1, 5'd1,  0, 0);
    vecs[2]  = mk("pop",         0,   1,   1,   2'b10, 64'h0,                  0,   4'd0, 5'd0,   64'h0,    4'd0, 5'd0,  1, 0);
    vecs[3]  = mk("pop_under",   0,   1,   1,   2'b10, 64'h0,                  0,   4'd0, 5'd0,   64'h0,    4'd0, 5'd0,  1, 0);
    vecs[4]  = mk("poppush_emp", 0,   1,   1,   2'b11, 64'h2000,               0,   4'd0, 5'd0,   64'h2004, 4'd0, 5'd1,  0, 0);
    vecs[5]  = mk("gate_vld",    0,   0,   1,   2'b01, 64'h3000,               0,   4'd0, 5'd0,   64'h2004, 4'd0, 5'd1,  0, 0);
    vecs[6]  = mk("gate_brext",  0,   1,   0,   2'b01, 64'h3000,               0,   4'd0, 5'd0,   64'h2004, 4'd0, 5'd1,  0, 0);
    vecs[7]  = mk("ctl_none",    0,   1,   1,   2'b00, 64'h3000,               0,   4'd0, 5'd0,   64'h2004, 4'd0, 5'd1,  0, 0);
    vecs[8]  = mk("push_wrap",   0,   1,   1,   2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 0,   4'd0, 5'd0,   64'h0,    4'd1, 5'd2,  0, 0);
    vecs[9]  = mk("pop2",        0,   1,   1,   2'b10, 64'h0,                  0,   4'd0, 5'd0,   64'h2004, 4'd0, 5'd1,  0, 0);
    vecs[10] = mk("flush_clamp", 0,   1,   1,   2'b01, 64'h5000,               1,   4'd5, 5'd31,  64'h0,    4'd5, 5'd16, 0, 1);
    vecs[11] = mk("flush_back",  0,   0,   0,   2'b00, 64'h0,                  1,   4'd0, 5'd1,   64'h2004, 4'd0, 5'd1,  0, 0);
    vecs[12] = mk("rst_vs_push", 1,   1,   1,   2'b01, 64'h6000,               1,   4'd3, 5'd3,   64'h0,    4'd0, 5'd0,  1, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].rst, vecs[i].vld, vecs[i].brext, vecs[i].ctl, vecs[i].dat,
          vecs[i].fl, vecs[i].ftos, vecs[i].fcnt);
      check_state(vecs[i].name, vecs[i].e_pc, vecs[i].e_tos, vecs[i].e_cnt,
                  vecs[i].e_empty, vecs[i].e_full);
    end

    // 17 pushes into a 16-deep stack: the 17th overwrites the oldest slot.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      push(64'h100 * k);
      if (k == 16) check_state("sat16", 64'h1004, 4'd0, 5'd16, 1'b0, 1'b1);
    end
    check_state("sat17", 64'h1104, 4'd1, 5'd16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("popseq.pc", rif.ras_pcdata_f0_o, 64'h100 * (17 - i) + 64'h4);
      pop();
    end
    check_state("drained", 64'h0, 4'd1, 5'd0, 1'b1, 1'b0);
    pop();
    check_state("pop17", 64'h0, 4'd1, 5'd0, 1'b1, 1'b0);

    // Checkpoint at tos=2/cnt=2; wrong path overwrites entry 2; restore is pointer-only.
    do_reset();
    push(64'hA0);
    push(64'hB0);
    check_state("ckpt", 64'hB4, 4'd2, 5'd2, 1'b0, 1'b0);
    pop();
    push(64'hC0);
    check_state("wrongpath", 64'hC4, 4'd2, 5'd2, 1'b0, 1'b0);
    pop();
    pop();
    check_state("wp_popped", 64'h0, 4'd0, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 64'hD0, 1'b1, 4'd2, 5'd2);
    check_state("restore", 64'hC4, 4'd2, 5'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 4'd3, 5'd3);
    check("no_push_on_flush", rif.ras_pcdata_f0_o, 64'h0);

    // Reset in the middle of a push clears pointers and every entry.
    do_reset();
    push(64'h10);
    push(64'h20);
    push(64'h30);
    check_state("pre_rst", 64'h34, 4'd3, 5'd3, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 2'b01, 64'h40, 1'b0, 4'h0, 5'h0);
    check_state("mid_rst", 64'h0, 4'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 4'(i), 5'd16);
      check("entry_clear", rif.ras_pcdata_f0_o, 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
